// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA-path definitions.
//   - Default visible resolution (H_ACTIVE_DEF x V_ACTIVE_DEF).
//   - 12-bit RGB444 colour constants for the pixel mux.
//   - Motion FSM state encoding (2-bit).
//   - axis_step(): one bounce/clamp step along a single axis.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] GREEN = 12'h0F0;
    localparam logic [11:0] BLUE  = 12'h00F;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_MOVE_X = 2'd1,
        MS_MOVE_Y = 2'd2
    } motion_state_e;

    typedef struct packed {
        logic [10:0] pos;
        logic        dir;   // 1 = moving towards larger coordinates
    } axis_t;

    // Moves pos by step in direction dir, clamping to [0, lim] and flipping
    // dir at either end. lim >= step always holds (step <= sprite size and
    // lim = screen - sprite), so "pos + step >= lim" is evaluated as
    // "pos >= lim - step" without needing an extra carry bit.
    function automatic axis_t axis_step(input logic [10:0] pos,
                                        input logic        dir,
                                        input logic [10:0] step,
                                        input logic [10:0] lim);
        axis_t r;
        r.pos = pos;
        r.dir = dir;
        if (dir) begin
            if (pos >= lim - step) begin
                r.pos = lim;
                r.dir = 1'b0;
            end else begin
                r.pos = pos + step;
            end
        end else if (pos <= step) begin
            r.pos = '0;
            r.dir = 1'b1;
        end else begin
            r.pos = pos - step;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: per-pixel image ROM addressing for the sprite window.
//   clk, rst_n      pixel clock, async active-low reset
//   x_pos, y_pos    sprite top-left corner
//   h_addr, v_addr  current scan position from the timing generator
//   frame_tick      start-of-vblank pulse, restarts the address counter
//   rom_address     ROM address, meaningful while the scan is in the window
//   pix_en          window flag delayed one cycle to line up with ROM q
module sprite_addr_gen
    import vga_pkg::*;
#(
    parameter int IMG_W = 62,
    parameter int IMG_H = 46
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] x_pos,
    input  logic [10:0] y_pos,
    input  logic [10:0] h_addr,
    input  logic [10:0] v_addr,
    input  logic        frame_tick,
    output logic [13:0] rom_address,
    output logic        pix_en
);

    localparam logic [13:0] ADDR_MAX = 14'(IMG_W * IMG_H - 1);
    localparam logic [11:0] W12      = 12'(IMG_W);
    localparam logic [11:0] H12      = 12'(IMG_H);

    logic [11:0] h12, v12, x12, y12;
    logic        in_win;
    logic [13:0] addr_q;
    logic        pix_en_q;

    // One spare bit so x_pos + IMG_W cannot wrap.
    assign h12 = {1'b0, h_addr};
    assign v12 = {1'b0, v_addr};
    assign x12 = {1'b0, x_pos};
    assign y12 = {1'b0, y_pos};

    assign in_win = (h12 >= x12) && (h12 < x12 + W12) &&
                    (v12 >= y12) && (v12 < y12 + H12);

    // Counter walks the sprite raster in scan order; it holds between rows
    // and saturates so a stray extra in-window cycle can never wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            pix_en_q <= 1'b0;
        end else begin
            pix_en_q <= in_win;
            if (frame_tick) begin
                addr_q <= '0;
            end else if (in_win && (addr_q != ADDR_MAX)) begin
                addr_q <= addr_q + 14'd1;
            end
        end
    end

    assign rom_address = addr_q;
    assign pix_en      = pix_en_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: bouncing-sprite controller for the VGA image ROM.
//   clk, rst_n      pixel clock (25.2 MHz), async active-low reset
//   pause           (only with SPRITE_PAUSE_EN) freezes motion, not addressing
//   h_addr, v_addr  scan position; >= H_ACTIVE / V_ACTIVE means blanking
//   rom_address     image ROM address (ROM has 1-cycle latency)
//   pix_en          ROM q holds a sprite pixel this cycle
//   x_pos, y_pos    sprite top-left corner
//   frame_tick      one-cycle pulse at the start of vertical blanking
// Optional feature macro: SPRITE_PAUSE_EN.
module sprite_motion_ctrl
    import vga_pkg::*;
#(
    parameter int IMG_W     = 62,
    parameter int IMG_H     = 46,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SPRITE_PAUSE_EN
    input  logic        pause,
`endif
    input  logic [10:0] h_addr,
    input  logic [10:0] v_addr,
    output logic [13:0] rom_address,
    output logic        pix_en,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output logic        frame_tick
);

    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - IMG_W);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - IMG_H);
    localparam logic [10:0] X_RST  = 11'((H_ACTIVE - IMG_W) / 2);
    localparam logic [10:0] Y_RST  = 11'((V_ACTIVE - IMG_H) / 2);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam int          DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    logic pause_i;
`ifdef SPRITE_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    // ---------------- frame detect ----------------
    logic vb, vb_d, tick_q;

    assign vb = (v_addr >= V_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vb_d   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            vb_d   <= vb;
            tick_q <= vb & ~vb_d;
        end
    end

    assign frame_tick = tick_q;

    // ---------------- frame divider ----------------
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic             upd;

    always_comb begin
        upd     = 1'b0;
        div_nxt = div_cnt;
        if (tick_q && !pause_i) begin
            if (div_cnt == DIV_LAST) begin
                upd     = 1'b1;
                div_nxt = '0;
            end else begin
                div_nxt = div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= div_nxt;
    end

    // ---------------- motion FSM ----------------
    // X then Y are stepped in the two cycles after frame_tick, which is deep
    // inside vertical blanking, so the window never moves mid-frame.
    motion_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MS_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE:   if (upd) state_d = MS_MOVE_X;
            MS_MOVE_X: state_d = MS_MOVE_Y;
            MS_MOVE_Y: state_d = MS_IDLE;
            default:   state_d = MS_IDLE;
        endcase
    end

    logic [10:0] x_q, y_q;
    logic        dx_q, dy_q;
    axis_t       x_nxt, y_nxt;

    assign x_nxt = axis_step(x_q, dx_q, STEP11, X_MAX);
    assign y_nxt = axis_step(y_q, dy_q, STEP11, Y_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= X_RST;
            y_q  <= Y_RST;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
        end else begin
            if (state_q == MS_MOVE_X) begin
                x_q  <= x_nxt.pos;
                dx_q <= x_nxt.dir;
            end
            if (state_q == MS_MOVE_Y) begin
                y_q  <= y_nxt.pos;
                dy_q <= y_nxt.dir;
            end
        end
    end

    assign x_pos = x_q;
    assign y_pos = y_q;

    // ---------------- addressing ----------------
    sprite_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .x_pos       (x_q),
        .y_pos       (y_q),
        .h_addr      (h_addr),
        .v_addr      (v_addr),
        .frame_tick  (tick_q),
        .rom_address (rom_address),
        .pix_en      (pix_en)
    );

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl. Three instances share one scan stream:
//   dut0: STEP=1 FRAME_DIV=1 (addressing + basic motion + right/bottom bounce)
//   dut1: STEP=4 (left clamp)
//   dut2: FRAME_DIV=4 (divider)
// Frames are compressed: only the rows/columns around dut0's window are
// scanned, and "short" frames just toggle v_addr into blanking.
module tb_sprite_motion_ctrl;

    localparam int IMG_W = 62;
    localparam int IMG_H = 46;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] h_addr = '0;
    logic [10:0] v_addr = '0;
`ifdef SPRITE_PAUSE_EN
    logic        pause = 1'b0;
`endif

    logic [13:0] rom_a [3];
    logic        pe    [3];
    logic [10:0] xo    [3];
    logic [10:0] yo    [3];
    logic        ft    [3];

    always #5 clk = ~clk;

    sprite_motion_ctrl #(.STEP(1), .FRAME_DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
`ifdef SPRITE_PAUSE_EN
        .pause(pause),
`endif
        .h_addr(h_addr), .v_addr(v_addr), .rom_address(rom_a[0]), .pix_en(pe[0]),
        .x_pos(xo[0]), .y_pos(yo[0]), .frame_tick(ft[0]));

    sprite_motion_ctrl #(.STEP(4), .FRAME_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef SPRITE_PAUSE_EN
        .pause(pause),
`endif
        .h_addr(h_addr), .v_addr(v_addr), .rom_address(rom_a[1]), .pix_en(pe[1]),
        .x_pos(xo[1]), .y_pos(yo[1]), .frame_tick(ft[1]));

    sprite_motion_ctrl #(.STEP(1), .FRAME_DIV(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
`ifdef SPRITE_PAUSE_EN
        .pause(pause),
`endif
        .h_addr(h_addr), .v_addr(v_addr), .rom_address(rom_a[2]), .pix_en(pe[2]),
        .x_pos(xo[2]), .y_pos(yo[2]), .frame_tick(ft[2]));

    typedef struct { int a; int h; int v; } pix_t;
    typedef struct { int x; int y; } pos_t;

    pix_t pix_q[$];
    pos_t pq0[$], pq1[$], pq2[$];

    int n_chk = 0, n_fail = 0;
    int pix_cnt = 0;
    int frames = 0;
    int ecnt = 0;
    bit paused = 1'b0;
    int mx[3], my[3], mdx[3], mdy[3], mdiv[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int step_of(input int k); return (k == 1) ? 4 : 1; endfunction
    function automatic int div_of(input int k);  return (k == 2) ? 4 : 1; endfunction

    function automatic int qsz(input int k);
        case (k)
            0:       return pq0.size();
            1:       return pq1.size();
            default: return pq2.size();
        endcase
    endfunction

    function automatic pos_t qpop(input int k);
        case (k)
            0:       return pq0.pop_front();
            1:       return pq1.pop_front();
            default: return pq2.pop_front();
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mx[k] = 289; my[k] = 217; mdx[k] = 1; mdy[k] = 1; mdiv[k] = 0;
        end
        ecnt = 0;
    endtask

    task automatic mv(inout int p, inout int d, input int s, input int lim);
        if (d != 0) begin
            if (p + s >= lim) begin p = lim; d = 0; end
            else p = p + s;
        end else begin
            if (p <= s) begin p = 0; d = 1; end
            else p = p - s;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one scan position; if it lies in dut0's window, queue the
    // address the ROM should be given there.
    task automatic drive(input int h, input int v);
        h_addr = 11'(h);
        v_addr = 11'(v);
        if (h >= mx[0] && h < mx[0] + IMG_W && v >= my[0] && v < my[0] + IMG_H) begin
            pix_q.push_back('{ecnt, h, v});
            ecnt++;
        end
        cyc();
    endtask

    // Enter vertical blanking: queue the position each DUT should show at
    // its frame_tick, then advance the motion model.
    task automatic blank();
        pq0.push_back('{mx[0], my[0]});
        pq1.push_back('{mx[1], my[1]});
        pq2.push_back('{mx[2], my[2]});
        if (!paused) begin
            for (int k = 0; k < 3; k++) begin
                mdiv[k]++;
                if (mdiv[k] == div_of(k)) begin
                    mdiv[k] = 0;
                    mv(mx[k], mdx[k], step_of(k), 640 - IMG_W);
                    mv(my[k], mdy[k], step_of(k), 480 - IMG_H);
                end
            end
        end
        ecnt = 0;
        repeat (5) drive(0, 480);
        frames++;
    endtask

    task automatic short_frame();
        drive(0, 0);
        drive(0, 0);
        blank();
    endtask

    task automatic scan_rows(input int nrows);
        int x0, y0;
        x0 = mx[0];
        y0 = my[0] - 1;
        for (int r = 0; r < nrows; r++) begin
            for (int h = x0 - 2; h <= x0 + IMG_W + 1; h++) drive(h, y0 + r);
            drive(700, y0 + r);
        end
    endtask

    task automatic scan_frame();
        pix_cnt = 0;
        scan_rows(IMG_H + 2);
        drive(0, 479);
        drive(0, 479);
        chk("pix_en_count", pix_cnt, 2852);
        chk("pix_queue_drained", pix_q.size(), 0);
        blank();
    endtask

    // Monitor: ROM address/pix_en scoreboard plus frame_tick position checks.
    int pv_rom = 0, pv_h = 0, pv_v = 0, v_d1 = 0, v_d2 = 0;
    always @(negedge clk) begin
        pix_t e;
        pos_t p;
        if (pe[0]) begin
            pix_cnt++;
            chk("pix_expected", pix_q.size() != 0, 1);
            if (pix_q.size() != 0) begin
                e = pix_q.pop_front();
                chk("rom_address", pv_rom, e.a);
                chk("pix_h", pv_h, e.h);
                chk("pix_v", pv_v, e.v);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (ft[k]) begin
                chk($sformatf("tick_expected%0d", k), qsz(k) != 0, 1);
                if (qsz(k) != 0) begin
                    p = qpop(k);
                    chk($sformatf("x_pos%0d", k), xo[k], p.x);
                    chk($sformatf("y_pos%0d", k), yo[k], p.y);
                end
                if (k == 0) begin
                    chk("tick_after_vb", v_d1 >= 480, 1);
                    chk("tick_first_vb", v_d2 < 480, 1);
                end
            end
        end
        pv_rom = int'(rom_a[0]);
        pv_h   = int'(h_addr);
        pv_v   = int'(v_addr);
        v_d2   = v_d1;
        v_d1   = int'(v_addr);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_x%0d", k), xo[k], 289);
            chk($sformatf("rst_y%0d", k), yo[k], 217);
            chk($sformatf("rst_tick%0d", k), ft[k], 0);
        end
        chk("rst_pix_en", pe[0], 0);
        chk("rst_rom", rom_a[0], 0);

        // Three fully scanned frames, window moving by one each frame.
        repeat (3) scan_frame();
        chk("basic_x", xo[0], 292);
        chk("basic_y", yo[0], 220);
        chk("div_x3", xo[2], 289);

        while (frames < 290) begin
            short_frame();
            if (frames == 7)   chk("div_x7", xo[2], 290);
            if (frames == 8)   chk("div_x8", xo[2], 291);
            if (frames == 217) chk("clamp_x217", xo[1], 2);
            if (frames == 218) chk("clamp_x218", xo[1], 0);
            if (frames == 219) chk("clamp_x219", xo[1], 4);
            if (frames == 289) chk("bounce_x289", xo[0], 578);
            if (frames == 290) begin
                chk("bounce_x290", xo[0], 577);
                chk("bounce_y290", yo[0], 361);
            end
        end

`ifdef SPRITE_PAUSE_EN
        paused = 1'b1;
        pause  = 1'b1;
        repeat (4) short_frame();
        scan_frame();
        chk("pause_x", xo[0], 577);
        chk("pause_y", yo[0], 361);
        paused = 1'b0;
        pause  = 1'b0;
`endif

        // Mid-frame reset after part of the sprite has been addressed.
        scan_rows(5);
        drive(0, 100);
        chk("rom_pre_reset", rom_a[0], 248);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mid_rst_x%0d", k), xo[k], 289);
            chk($sformatf("mid_rst_y%0d", k), yo[k], 217);
            chk($sformatf("mid_rst_tick%0d", k), ft[k], 0);
        end
        chk("mid_rst_rom", rom_a[0], 0);
        chk("mid_rst_pix_en", pe[0], 0);
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        scan_frame();
        chk("post_rst_x", xo[0], 290);
        chk("post_rst_y", yo[0], 218);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Controller that sequences the on-screen image ROM for the VGA path: it holds the sprite's top-left position, moves it by a fixed step once every N frames, and reverses direction at the screen edges. It also generates the per-pixel ROM address and a display-enable flag aligned to ROM output. It sits between the VGA timing generator (`h_addr`/`v_addr`) and the image ROM plus pixel mux. It replaces the fixed centred-window addressing.

## Interface
- `IMG_W`, 62: sprite width in pixels.
- `IMG_H`, 46: sprite height in pixels.
- `H_ACTIVE`, 640: visible columns.
- `V_ACTIVE`, 480: visible rows.
- `STEP`, 1: pixels moved per axis per update. Legal range 1..IMG_W.
- `FRAME_DIV`, 1: frames per position update. Must be ≥1.

Ports:
- `clk`  in  1  VGA pixel clock, 25.2 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `h_addr`  in  11  current column. Values ≥ `H_ACTIVE` mean blanking.
- `v_addr`  in  11  current row. Values ≥ `V_ACTIVE` mean blanking.
- `rom_address`  out  14  image ROM address (1-cycle-latency ROM).
- `pix_en`  out  1  ROM `q` is a valid sprite pixel this cycle.
- `x_pos`  out  11  sprite left column.
- `y_pos`  out  11  sprite top row.
- `frame_tick`  out  1  single-cycle pulse at start of vertical blanking.

## Operation
- **In-window test** (combinational): `in_win` = (`x_pos` ≤ `h_addr` < `x_pos`+`IMG_W`) and (`y_pos` ≤ `v_addr` < `y_pos`+`IMG_H`). All comparisons are 12-bit unsigned, so there is no overflow.
- **Frame detect**: `vb` = (`v_addr` ≥ `V_ACTIVE`). `vb_d` is `vb` registered. `frame_tick` = `vb` & !`vb_d`, registered.
- **Address counter**:
  - On `frame_tick`, clear to 0.
  - Otherwise, if `in_win`, increment.
  - Otherwise, hold.
  - Saturate at `IMG_W*IMG_H-1`; it never wraps within a frame.
  - `rom_address` is the counter value; it is valid while `in_win`.
- **pix_en**: `in_win` registered, so it is aligned with ROM `q`.
- **Divider**: `div_cnt` counts 0..`FRAME_DIV`-1 on `frame_tick`. `upd` is asserted when `frame_tick` occurs and `div_cnt` == `FRAME_DIV`-1. `div_cnt` then wraps to 0.
- **Motion FSM** (states IDLE, MOVE_X, MOVE_Y):
  - IDLE → MOVE_X when `upd`.
  - MOVE_X → MOVE_Y unconditionally.
  - MOVE_Y → IDLE unconditionally.
- **MOVE_X** (`dx`=1 means +):
  - If `dx` and `x_pos`+`STEP` ≥ `H_ACTIVE`-`IMG_W`: set `x_pos` = `H_ACTIVE`-`IMG_W` and `dx` = 0.
  - If !`dx` and `x_pos` ≤ `STEP`: set `x_pos` = 0 and `dx` = 1.
  - Otherwise, `x_pos` ± `STEP`.
- **MOVE_Y**: same rule using `y_pos`, `dy`, `V_ACTIVE`, `IMG_H`.
- Position is always within [0, `H_ACTIVE`-`IMG_W`] × [0, `V_ACTIVE`-`IMG_H`].

## Timing
- Reset values:
  - `x_pos` = (`H_ACTIVE`-`IMG_W`)/2 = 289; `y_pos` = (`V_ACTIVE`-`IMG_H`)/2 = 217.
  - `dx` = `dy` = 1; FSM = IDLE; `div_cnt` = 0.
  - `rom_address` = 0; `pix_en` = 0; `frame_tick` = 0; `vb_d` = 0.
- ROM latency is 1 cycle, and `pix_en` lags `in_win` by 1 cycle. The pixel mux selects `q` when `pix_en` is high, else black.
- Position changes happen only in the 2 cycles after `frame_tick`, inside vertical blanking. The window is therefore constant across an entire active frame, and exactly `IMG_W*IMG_H` addresses are emitted per frame.
- `frame_tick` and `in_win` are mutually exclusive, because `in_win` requires `v_addr` < `V_ACTIVE`.
- `upd` arriving while the FSM is not in IDLE is impossible: frames are far longer than 3 cycles. The RTL still ignores such an `upd`.
- Reset asserted mid-frame: all state returns to reset values immediately. The remainder of that frame may show a shifted sprite. The next frame is correct.

## Configuration
- `SPRITE_PAUSE_EN`: when defined, adds input port `pause` (1 bit, synchronous).
  - While `pause`=1, `upd` is suppressed and `div_cnt` holds.
  - Addressing and `frame_tick` continue unaffected.
- Without the macro, the port is absent and motion is free-running.

## Structure
- Shared package `vga_pkg`:
  - Defaults for `H_ACTIVE` and `V_ACTIVE`.
  - Colour constants (BLACK, WHITE, …).
  - Motion FSM state encoding (2-bit).
- One sub-module, `sprite_addr_gen`: contains the in-window compare, the address counter and the `pix_en` register. Inputs are `x_pos`, `y_pos`, `h_addr`, `v_addr` and `frame_tick`.
- The top level holds frame detect, the divider and the motion FSM.

## Test plan
- **Reset check**: after reset, check `x_pos`=289, `y_pos`=217. Over one full frame, `pix_en` is high for exactly 2852 cycles. `rom_address` runs 0..2851, and the first `pix_en` appears at `h_addr`=290, `v_addr`=217 (+1 cycle).
- **Basic motion**: with `FRAME_DIV`=1 and `STEP`=1, after 3 frames `x_pos`=292 and `y_pos`=220. `frame_tick` pulses exactly once per frame, on the cycle after `v_addr` first reaches 480.
- **Right-edge bounce**: force `x_pos` near the edge by starting at 577 with `dx`=1. After 1 update, `x_pos`=578 and `dx`=0. After the next update, `x_pos`=577.
- **Left/top clamp**: with `STEP`=4, start at `x_pos`=3 with `dx`=0. After the update, `x_pos`=0 and `dx`=1.
- **Divider**: with `FRAME_DIV`=4, position changes only on every 4th `frame_tick`, giving 2 moves over 8 frames.
- **Pause and mid-frame reset**: with `SPRITE_PAUSE_EN` and `pause`=1 for 5 frames, position is unchanged while `pix_en` counts stay at 2852 per frame. Assert `rst_n` low at `v_addr`=100: outputs return to reset values within the same cycle.
